// File: rtl/mulbyn_stream_if.sv
// Handshake and data bundle for the multiply-by-N streaming scaler.
// The scaler owns the 'slave' side; the producer and consumer drive the 'master' side.
interface mulbyn_stream_if #(
  parameter int N = 16,
  parameter int W = 16
);
  localparam int IW = $clog2(N);

  logic                 in_valid;
  logic                 in_ready;
  logic signed [W:0]    in_re;
  logic signed [W:0]    in_im;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [W:0]    out_re;
  logic signed [W:0]    out_im;
  logic [IW-1:0]        out_idx;
  logic                 out_last;
  logic                 sat_flag;
  logic                 clr_sat;

  modport slave (
    input  in_valid, in_re, in_im, out_ready, clr_sat,
    output in_ready, out_valid, out_re, out_im, out_idx, out_last, sat_flag
  );

  modport master (
    output in_valid, in_re, in_im, out_ready, clr_sat,
    input  in_ready, out_valid, out_re, out_im, out_idx, out_last, sat_flag
  );
endinterface

// File: rtl/mulbyn_stream.sv
// Streaming complex scaler: y = sat(x * N) per component, 1-cycle registered
// output stage with valid/ready, in-frame sample index and sticky saturation flag.

// One component lane: scale by N and clamp to the signed [W:0] range.
module mulbyn_stream_lane #(
  parameter int N = 16,
  parameter int W = 16
) (
  input  logic signed [W:0] x_i,
  output logic signed [W:0] y_o,
  output logic              sat_o
);
  localparam int P    = $clog2(N);
  localparam bit POW2 = ((1 << P) == N);
  // Power-of-two scale is a pure shift; otherwise one extra bit covers N < 2^P.
  localparam int PW   = POW2 ? (W + 1 + P) : (W + 2 + P);

  localparam logic signed [PW-1:0] MAXV = {{(PW-W){1'b0}}, {W{1'b1}}};
  localparam logic signed [PW-1:0] MINV = {{(PW-W){1'b1}}, {W{1'b0}}};
  localparam logic signed [PW-1:0] NK   = PW'(N);

  logic signed [PW-1:0] xe;
  logic signed [PW-1:0] prod;
  logic                 hi, lo;

  assign xe = {{(PW-W-1){x_i[W]}}, x_i};

  generate
    if (POW2) begin : g_shift
      assign prod = xe <<< P;
    end else begin : g_mult
      assign prod = xe * NK;
    end
  endgenerate

  // Clamp the wide product back into the data format.
  always_comb begin
    hi    = (prod > MAXV);
    lo    = (prod < MINV);
    sat_o = hi | lo;
    y_o   = prod[W:0];
    if (hi)      y_o = MAXV[W:0];
    else if (lo) y_o = MINV[W:0];
  end
endmodule

module mulbyn_stream #(
  parameter int N        = 16,
  parameter int W        = 16,
  parameter int BIT_FRAC = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  mulbyn_stream_if.slave bus
);
  localparam int IW = $clog2(N);
  localparam int NC = 2;  // component lanes: 0 = real, 1 = imaginary
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  logic [NC-1:0][W:0] x_lane, y_lane;
  logic [NC-1:0]      sat_lane;

  logic               vld_q, vld_d;
  logic [NC-1:0][W:0] data_q, data_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic               last_q, last_d;
  logic [IW-1:0]      cnt_q, cnt_d;
  logic               sat_q, sat_d;

  logic in_rdy, acc, xfer;

  assign x_lane[0] = bus.in_re;
  assign x_lane[1] = bus.in_im;

  generate
    for (genvar c = 0; c < NC; c++) begin : g_lane
      mulbyn_stream_lane #(.N(N), .W(W)) u_lane (
        .x_i   (x_lane[c]),
        .y_o   (y_lane[c]),
        .sat_o (sat_lane[c])
      );
    end
  endgenerate

  // Output slot frees up when empty or being drained this cycle.
  assign in_rdy = !vld_q || bus.out_ready;
  assign acc    = bus.in_valid && in_rdy;
  assign xfer   = vld_q && bus.out_ready;

  // Next state: load on accept, drop valid on a bare transfer, else hold.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    idx_d  = idx_q;
    last_d = last_q;
    cnt_d  = cnt_q;
    sat_d  = sat_q;
    if (bus.clr_sat) sat_d = 1'b0;
    if (acc) begin
      vld_d  = 1'b1;
      data_d = y_lane;
      idx_d  = cnt_q;
      last_d = (cnt_q == LAST_IDX);
      cnt_d  = (cnt_q == LAST_IDX) ? '0 : cnt_q + IW'(1);
      // A saturating accept overrides a simultaneous clear.
      if (|sat_lane) sat_d = 1'b1;
    end else if (xfer) begin
      vld_d  = 1'b0;
    end
  end

  // Output register stage and frame counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      idx_q  <= '0;
      last_q <= 1'b0;
      cnt_q  <= '0;
      sat_q  <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      idx_q  <= idx_d;
      last_q <= last_d;
      cnt_q  <= cnt_d;
      sat_q  <= sat_d;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = vld_q;
  assign bus.out_re    = data_q[0];
  assign bus.out_im    = data_q[1];
  assign bus.out_idx   = idx_q;
  assign bus.out_last  = last_q;
  assign bus.sat_flag  = sat_q;
endmodule

// File: tb/tb_mulbyn_stream.sv
// Bench for mulbyn_stream: two instances (N=16 and N=12) checked every cycle
// against an integer-arithmetic model, plus hand-computed literal checks.
module tb_mulbyn_stream;
  localparam int W    = 16;
  localparam int MAXV = 65535;
  localparam int MINV = -65536;

  logic clk;
  logic rst_n;

  logic              iv   [2];
  logic signed [W:0] ire  [2];
  logic signed [W:0] iim  [2];
  logic              ordy [2];
  logic              clr  [2];

  logic              o_rdy  [2];
  logic              o_vld  [2];
  logic signed [W:0] o_re   [2];
  logic signed [W:0] o_im   [2];
  logic [3:0]        o_idx  [2];
  logic              o_last [2];
  logic              o_sat  [2];

  int checks   = 0;
  int failures = 0;

  // model state
  bit m_vld [2];
  int m_re  [2];
  int m_im  [2];
  int m_idx [2];
  int m_cnt [2];
  bit m_sat [2];

  mulbyn_stream_if #(.N(16), .W(W)) if0 ();
  mulbyn_stream_if #(.N(12), .W(W)) if1 ();

  assign if0.in_valid = iv[0];   assign if1.in_valid = iv[1];
  assign if0.in_re = ire[0];     assign if1.in_re = ire[1];
  assign if0.in_im = iim[0];     assign if1.in_im = iim[1];
  assign if0.out_ready = ordy[0]; assign if1.out_ready = ordy[1];
  assign if0.clr_sat = clr[0];   assign if1.clr_sat = clr[1];

  assign o_rdy[0] = if0.in_ready;   assign o_rdy[1] = if1.in_ready;
  assign o_vld[0] = if0.out_valid;  assign o_vld[1] = if1.out_valid;
  assign o_re[0] = if0.out_re;      assign o_re[1] = if1.out_re;
  assign o_im[0] = if0.out_im;      assign o_im[1] = if1.out_im;
  assign o_idx[0] = if0.out_idx;    assign o_idx[1] = if1.out_idx;
  assign o_last[0] = if0.out_last;  assign o_last[1] = if1.out_last;
  assign o_sat[0] = if0.sat_flag;   assign o_sat[1] = if1.sat_flag;

  mulbyn_stream #(.N(16), .W(W), .BIT_FRAC(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  mulbyn_stream #(.N(12), .W(W), .BIT_FRAC(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int nn(input int d);
    return (d == 0) ? 16 : 12;
  endfunction

  function automatic int clampv(input int v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  task automatic chk(input string nm, input int d, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s dut%0d got %0d expected %0d at %0t", nm, d, act, exp, $time);
    end
  endtask

  // Reference model: product computed in plain integers, then clamped.
  always @(posedge clk or negedge rst_n) begin
    int  r, i;
    bit  rdy, acc, s;
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_vld[d] = 0; m_re[d] = 0; m_im[d] = 0;
        m_idx[d] = 0; m_cnt[d] = 0; m_sat[d] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        rdy = !m_vld[d] || ordy[d];
        acc = iv[d] && rdy;
        s   = 0;
        if (acc) begin
          r = int'(ire[d]) * nn(d);
          i = int'(iim[d]) * nn(d);
          s = (r != clampv(r)) || (i != clampv(i));
          m_re[d]  = clampv(r);
          m_im[d]  = clampv(i);
          m_idx[d] = m_cnt[d];
          m_cnt[d] = (m_cnt[d] + 1) % nn(d);
          m_vld[d] = 1;
        end else if (m_vld[d] && ordy[d]) begin
          m_vld[d] = 0;
        end
        if (acc && s)    m_sat[d] = 1;
        else if (clr[d]) m_sat[d] = 0;
      end
    end
  end

  // Compare every output of both instances against the model each cycle.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      chk("in_ready",  d, int'(o_rdy[d]), int'(!m_vld[d] || ordy[d]));
      chk("out_valid", d, int'(o_vld[d]), int'(m_vld[d]));
      chk("out_re",    d, int'(o_re[d]),  m_re[d]);
      chk("out_im",    d, int'(o_im[d]),  m_im[d]);
      chk("out_idx",   d, int'(o_idx[d]), m_idx[d]);
      chk("out_last",  d, int'(o_last[d]), int'(m_idx[d] == nn(d) - 1));
      chk("sat_flag",  d, int'(o_sat[d]), int'(m_sat[d]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      iv[d] = 0; ire[d] = '0; iim[d] = '0; ordy[d] = 1; clr[d] = 0;
    end
    step();
    step();
    // reset state
    chk("rst_valid", 0, int'(o_vld[0]), 0);
    chk("rst_re",    0, int'(o_re[0]),  0);
    chk("rst_idx",   0, int'(o_idx[0]), 0);
    chk("rst_sat",   0, int'(o_sat[0]), 0);
    chk("rst_ready", 0, int'(o_rdy[0]), 1);
    rst_n = 1'b1;
    step();

    // basic scale: 100*16, -3*16
    ire[0] = 17'sd100; iim[0] = -17'sd3; iv[0] = 1;
    step();
    iv[0] = 0;
    @(negedge clk);
    chk("t1_valid", 0, int'(o_vld[0]), 1);
    chk("t1_re",    0, int'(o_re[0]),  1600);
    chk("t1_im",    0, int'(o_im[0]),  -48);
    chk("t1_idx",   0, int'(o_idx[0]), 0);
    chk("t1_last",  0, int'(o_last[0]), 0);
    chk("t1_sat",   0, int'(o_sat[0]), 0);

    // saturation: 4096*16 clamps high, -4096*16 exactly at the floor
    step();
    ire[0] = 17'sd4096; iim[0] = -17'sd4096; iv[0] = 1;
    step();
    iv[0] = 0;
    @(negedge clk);
    chk("t2_re",  0, int'(o_re[0]),  65535);
    chk("t2_im",  0, int'(o_im[0]),  -65536);
    chk("t2_sat", 0, int'(o_sat[0]), 1);
    step();
    clr[0] = 1;
    step();
    clr[0] = 0;
    @(negedge clk);
    chk("t2_clr", 0, int'(o_sat[0]), 0);
    step();
    ire[0] = 17'sd4096; iim[0] = 17'sd0; iv[0] = 1; clr[0] = 1;
    step();
    iv[0] = 0; clr[0] = 0;
    @(negedge clk);
    chk("t2_setwins", 0, int'(o_sat[0]), 1);
    step();
    clr[0] = 1;
    step();
    clr[0] = 0;

    // fresh frame, 20 back-to-back samples
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      ire[0] = 17'(k * 5 - 40); iim[0] = 17'(-k); iv[0] = 1;
      step();
      @(negedge clk);
      chk("t3_idx",  0, int'(o_idx[0]),  k % 16);
      chk("t3_last", 0, int'(o_last[0]), int'((k % 16) == 15));
      chk("t3_valid", 0, int'(o_vld[0]), 1);
      #1;
    end
    iv[0] = 0;
    step();

    // backpressure: held sample must stay put, then transfer + accept together
    ordy[0] = 0; ire[0] = 17'sd7; iim[0] = 17'sd1; iv[0] = 1;
    step();
    ire[0] = 17'sd9; iim[0] = -17'sd2;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_ready", 0, int'(o_rdy[0]), 0);
      chk("t4_re",    0, int'(o_re[0]),  112);
      chk("t4_im",    0, int'(o_im[0]),  16);
      chk("t4_idx",   0, int'(o_idx[0]), 4);
      step();
    end
    ordy[0] = 1;
    @(negedge clk);
    chk("t4_ready_up", 0, int'(o_rdy[0]), 1);
    step();
    iv[0] = 0;
    @(negedge clk);
    chk("t4_next_re",  0, int'(o_re[0]),  144);
    chk("t4_next_im",  0, int'(o_im[0]),  -32);
    chk("t4_next_idx", 0, int'(o_idx[0]), 5);
    step();

    // N=12: non-power-of-two scale and wrap 11 -> 0
    for (int k = 0; k < 13; k++) begin
      ire[1] = (k == 0) ? 17'sd5  : 17'(k * 1000);
      iim[1] = (k == 0) ? -17'sd7 : 17'(-k * 3000);
      iv[1]  = 1;
      step();
      @(negedge clk);
      if (k == 0) begin
        chk("t5_re", 1, int'(o_re[1]), 60);
        chk("t5_im", 1, int'(o_im[1]), -84);
      end
      if (k == 6) chk("t5_satre", 1, int'(o_re[1]), 65535);
      chk("t5_idx",  1, int'(o_idx[1]),  k % 12);
      chk("t5_last", 1, int'(o_last[1]), int'(k == 11));
      #1;
    end
    iv[1] = 0;
    step();

    // async reset mid-frame at idx 7
    ire[0] = 17'sd1; iim[0] = 17'sd0; iv[0] = 1;
    step();
    ire[0] = 17'sd2;
    step();
    iv[0] = 0;
    chk("t6_pre_idx",   0, int'(o_idx[0]), 7);
    chk("t6_pre_valid", 0, int'(o_vld[0]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_valid", 0, int'(o_vld[0]),  0);
    chk("t6_re",    0, int'(o_re[0]),   0);
    chk("t6_idx",   0, int'(o_idx[0]),  0);
    chk("t6_last",  0, int'(o_last[0]), 0);
    chk("t6_ready", 0, int'(o_rdy[0]),  1);
    step();
    rst_n = 1'b1;
    ire[0] = 17'sd3; iv[0] = 1;
    step();
    iv[0] = 0;
    @(negedge clk);
    chk("t6_after_idx", 0, int'(o_idx[0]), 0);
    chk("t6_after_re",  0, int'(o_re[0]),  48);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mulbyn_stream.md
Name: mulbyn_stream

Overview:
Streaming complex-sample scaler that multiplies each sample by the transform length N, the inverse of the per-frame 1/N normalisation. It is used on the forward-FFT path to restore unnormalised magnitudes. It accepts one complex sample per cycle over a valid/ready handshake, saturates results to the W+1-bit signed data format, and tracks the sample position within an N-sample frame. It sits between a normalised-domain producer and the FFT core input.

Parameters:
N, 16, frame length and scale factor; integer >= 2.
W, 16, data MSB index; samples are signed [W:0] (W+1 bits).
BIT_FRAC, 1, fractional bits of the data format. Carried for format consistency only; it does not affect the arithmetic (integer scale).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  input sample valid.
in_ready  out  1  block can accept a sample this cycle.
in_re  in  W+1 signed  input real part.
in_im  in  W+1 signed  input imaginary part.
out_valid  out  1  output sample valid.
out_ready  in  1  downstream accepts output.
out_re  out  W+1 signed  scaled real part.
out_im  out  W+1 signed  scaled imaginary part.
out_idx  out  $clog2(N)  position of the output sample in its frame, 0..N-1.
out_last  out  1  high with the sample at out_idx == N-1.
sat_flag  out  1  sticky; set if any component has saturated since the last clear.
clr_sat  in  1  synchronous clear of sat_flag.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_re=0, out_im=0, out_idx=0, out_last=0, sat_flag=0. Reset mid-frame discards the partial frame; the next accepted sample gets index 0.
- Handshake: in_ready = !out_valid || out_ready (combinational).
  - Input accept when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - in_ready is 1 during and after reset.
- Latency: exactly 1 cycle. A sample accepted at edge k appears on the outputs after edge k with out_valid=1.
- Output register update:
  - On accept: load the new result and set out_valid=1.
  - Else on transfer: clear out_valid.
  - Else: hold all outputs stable. The held value must not change while out_valid=1 and out_ready=0.
  - Accept and transfer in the same cycle (full throughput) load the new sample with no bubble.
- Arithmetic, per component:
  - If N is a power of two: p = $clog2(N); result = x <<< p, computed at W+1+p bits before saturation.
  - Otherwise: result = x * N, with x sign-extended and product width W+1+$clog2(N)+1.
- Saturation range is [-2^W, 2^W-1]:
  - Above the range: output 2^W-1.
  - Below the range: output -2^W.
  - Each component saturates independently.
- Frame counter:
  - Increments on each input accept.
  - Wraps from N-1 to 0; this also holds for non-power-of-two N, e.g. N=12 wraps 11->0.
  - out_idx is registered alongside the data and equals the accepted sample's index.
  - out_last = (out_idx == N-1).
- sat_flag:
  - Set on an accept cycle where either component saturates.
  - Cleared by clr_sat.
  - If set and clear occur in the same cycle, set wins.
  - The flag is visible one cycle after the saturating accept, i.e. together with that sample's out_valid.
- in_valid is ignored while in_ready=0. Input data need not be held by the source after acceptance.

Test Plan:
1. N=16, W=16. Feed in_re=100, in_im=-3 with out_ready=1 -> next cycle out_re=1600, out_im=-48, out_idx=0, out_last=0, sat_flag=0.
2. N=16. Feed in_re=4096, in_im=-4096 -> out_re=65535 (saturated), out_im=-65536 (exact, not saturated), sat_flag=1 the same cycle as out_valid. Then pulse clr_sat -> sat_flag=0. Pulse clr_sat together with another saturating accept -> sat_flag stays 1.
3. N=16. Stream 20 back-to-back samples with out_ready=1 -> one output per cycle, out_idx 0..15 then 0..3, out_last high only at idx 15.
4. Backpressure. Hold out_ready=0 for 3 cycles with the output valid -> in_ready=0, out_re/out_im/out_idx stable. Raise out_ready -> the held sample transfers and the next pending input is accepted in the same cycle.
5. N=12 (non-power-of-two). Feed in_re=5, in_im=-7 -> out_re=60, out_im=-84. Feed 13 samples -> out_last at the 12th, out_idx wraps 11->0.
6. Assert rst_n low asynchronously at out_idx=7 with out_valid=1 -> outputs clear immediately with no clock edge. After release, the next sample has out_idx=0.
